// File: rtl/gfx_mem_arbiter.sv
// N-client round-robin VRAM arbiter: one registered command stage toward memory,
// with an in-order tag FIFO that routes read responses back to the issuing client.
module gfx_mem_arbiter #(
  parameter int CLIENTS     = 4,
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CLIENTS*ADDR_W-1:0]     cli_address,
  input  logic [CLIENTS-1:0]            cli_read,
  input  logic [CLIENTS-1:0]            cli_write,
  input  logic [CLIENTS*DATA_W-1:0]     cli_writedata,
  output logic [CLIENTS-1:0]            cli_waitrequest,
  output logic [CLIENTS-1:0]            cli_readdatavalid,
  output logic [DATA_W-1:0]             cli_readdata,
  output logic [ADDR_W-1:0]             mem_address,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_writedata,
  input  logic                          mem_waitrequest,
  input  logic                          mem_readdatavalid,
  input  logic [DATA_W-1:0]             mem_readdata,
  output logic [$clog2(MAX_PENDING):0]  pending,
  output logic                          err
);
  localparam int TW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;

  typedef enum logic {S_EMPTY, S_FULL} stage_e;

  stage_e              st_q, st_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [TW-1:0]       tag_q;
  logic [TW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       wp_q, rp_q;
  logic                err_q, err_d;
  logic [TW-1:0]       fifo_q [MAX_PENDING];

  logic                full, can_load, push, pop, credit, grant;
  logic [TW-1:0]       win;
  logic [CW:0]         rd_load;
  logic [CLIENTS-1:0]  elig;
  int                  idx;

  // ---------------- stage FSM: register / next-state / outputs
  always_ff @(posedge clk) begin
    if (rst) st_q <= S_EMPTY;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_EMPTY: if (grant) st_d = S_FULL;
      S_FULL:  if (!mem_waitrequest && !grant) st_d = S_EMPTY;
      default: st_d = S_EMPTY;
    endcase
  end

  always_comb begin
    full          = (st_q == S_FULL);
    mem_read      = full & ~wr_q;
    mem_write     = full & wr_q;
    mem_address   = addr_q;
    mem_writedata = wdata_q;
  end

  // ---------------- arbitration
  always_comb begin
    can_load = !full || !mem_waitrequest;
    push     = mem_read && !mem_waitrequest;
    pop      = mem_readdatavalid && (cnt_q != '0);
    // Reads in the stage will land in the FIFO, so they already consume credit.
    rd_load  = {1'b0, cnt_q} + {{CW{1'b0}}, mem_read} - {{CW{1'b0}}, pop};
    credit   = rd_load < (CW+1)'(MAX_PENDING);
    elig     = cli_write | (cli_read & {CLIENTS{credit}});
  end

  always_comb begin
    grant = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < CLIENTS; k++) begin
      idx = (int'(ptr_q) + k) % CLIENTS;
      if (!grant && can_load && elig[idx]) begin
        grant = 1'b1;
        win   = TW'(idx);
      end
    end
  end

  assign cli_waitrequest = grant ? ~(CLIENTS'(1) << win) : {CLIENTS{1'b1}};

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (win == TW'(CLIENTS-1)) ? '0 : win + 1'b1;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    err_d = err_q
          | (grant && cli_write[win] && cli_read[win])
          | (mem_readdatavalid && cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        wr_q    <= cli_write[win];
        addr_q  <= cli_address[win*ADDR_W +: ADDR_W];
        wdata_q <= cli_writedata[win*DATA_W +: DATA_W];
        tag_q   <= win;
      end
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wp_q] <= tag_q;
  end

  // ---------------- response routing (zero-cycle)
  assign cli_readdata      = mem_readdata;
  assign cli_readdatavalid = pop ? (CLIENTS'(1) << fifo_q[rp_q]) : '0;
  assign pending           = cnt_q;
  assign err               = err_q;
endmodule

// File: tb/tb_gfx_mem_arbiter.sv
// Randomized scoreboard bench for gfx_mem_arbiter plus directed credit and reset scenarios.
module tb_gfx_mem_arbiter;
  localparam int C  = 4;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int MP = 4;
  localparam int PW = $clog2(MP) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [C*AW-1:0] cli_address;
  logic [C-1:0]    cli_read, cli_write;
  logic [C*DW-1:0] cli_writedata;
  logic [C-1:0]    cli_waitrequest, cli_readdatavalid;
  logic [DW-1:0]   cli_readdata;
  logic [AW-1:0]   mem_address;
  logic            mem_read, mem_write;
  logic [DW-1:0]   mem_writedata;
  logic            mem_waitrequest, mem_readdatavalid;
  logic [DW-1:0]   mem_readdata;
  logic [PW-1:0]   pending;
  logic            err;

  gfx_mem_arbiter #(.CLIENTS(C), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) dut (
    .clk(clk), .rst(rst),
    .cli_address(cli_address), .cli_read(cli_read), .cli_write(cli_write),
    .cli_writedata(cli_writedata), .cli_waitrequest(cli_waitrequest),
    .cli_readdatavalid(cli_readdatavalid), .cli_readdata(cli_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; int cli; } cmd_t;
  typedef struct { int cli; logic [DW-1:0] data; } rsp_t;

  cmd_t          cmd_q[$];
  rsp_t          exp_rsp_q[$];
  logic [DW-1:0] mem_q[$];

  int tests = 0, fails = 0;

  // Client/arbiter model state
  bit            req_v[C], req_rd[C], req_wr[C];
  logic [AW-1:0] req_a[C];
  logic [DW-1:0] req_d[C];
  int            ptr, outst, stage_cnt;
  bit            exp_err;

  // Monitor state
  bit            mon_en = 1'b0;
  int            mon_pend;
  bit            prev_busy;
  logic [AW-1:0] prev_a;
  logic [DW-1:0] prev_d;
  logic [1:0]    prev_op;
  cmd_t          m_cmd;
  rsp_t          m_rsp;
  logic [DW-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cli_read = '0; cli_write = '0; cli_address = '0; cli_writedata = '0;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
  endtask

  // One random cycle: drive inputs, predict the grant from the arbitration rules, log it.
  task automatic cycle_step(input bit allow_new);
    int r, w, i;
    bit can_load, credit;
    logic [C-1:0] exp_wait;
    @(posedge clk); #1;
    for (int k = 0; k < C; k++) begin
      if (!req_v[k] && allow_new && $urandom_range(0, 99) < 40) begin
        r = $urandom_range(0, 99);
        req_v[k]  = 1'b1;
        req_rd[k] = (r < 45) || (r >= 90);
        req_wr[k] = (r >= 45);
        req_a[k]  = AW'($urandom);
        req_d[k]  = DW'($urandom);
      end
      cli_read[k]              = req_v[k] && req_rd[k];
      cli_write[k]             = req_v[k] && req_wr[k];
      cli_address[k*AW +: AW]  = req_a[k];
      cli_writedata[k*DW +: DW] = req_d[k];
    end
    mem_waitrequest = ($urandom_range(0, 3) == 0);
    if (mem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = mem_q.pop_front();
    end else begin
      mem_readdatavalid = 1'b0;
      mem_readdata      = DW'($urandom);
    end
    #1;
    can_load = (stage_cnt == 0) || !mem_waitrequest;
    credit   = (outst - int'(mem_readdatavalid)) < MP;
    w = -1;
    for (int k = 0; k < C; k++) begin
      i = (ptr + k) % C;
      if (w < 0 && can_load && req_v[i] && (req_wr[i] || (req_rd[i] && credit))) w = i;
    end
    exp_wait = '1;
    if (w >= 0) exp_wait[w] = 1'b0;
    chk("waitrequest", cli_waitrequest, exp_wait);
    if (stage_cnt > 0 && !mem_waitrequest) stage_cnt--;
    if (mem_readdatavalid) outst--;
    if (w >= 0) begin
      cmd_q.push_back('{req_wr[w], req_a[w], req_d[w], w});
      if (!req_wr[w]) outst++;
      if (req_wr[w] && req_rd[w]) exp_err = 1'b1;
      ptr = (w + 1) % C;
      req_v[w] = 1'b0;
      stage_cnt++;
    end
  endtask

  // Monitor: memory-side commands and client-side responses against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pending", pending, mon_pend);
      if (prev_busy) begin
        chk("hold_op", {mem_read, mem_write}, prev_op);
        chk("hold_addr", mem_address, prev_a);
        if (prev_op == 2'b01) chk("hold_data", mem_writedata, prev_d);
      end
      if ((mem_read || mem_write) && !mem_waitrequest) begin
        if (cmd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL cmd_unexpected: got op %b expected none", {mem_read, mem_write});
        end else begin
          m_cmd = cmd_q.pop_front();
          chk("cmd_op", {mem_read, mem_write}, m_cmd.wr ? 2'b01 : 2'b10);
          chk("cmd_addr", mem_address, m_cmd.addr);
          if (m_cmd.wr) chk("cmd_data", mem_writedata, m_cmd.data);
          else begin
            m_data = DW'($urandom);
            mem_q.push_back(m_data);
            exp_rsp_q.push_back('{m_cmd.cli, m_data});
            mon_pend++;
          end
        end
      end
      if (mem_readdatavalid) begin
        if (exp_rsp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rsp_unexpected: got strobe %b expected none", cli_readdatavalid);
        end else begin
          m_rsp = exp_rsp_q.pop_front();
          chk("rsp_strobe", cli_readdatavalid, C'(1) << m_rsp.cli);
          chk("rsp_data", cli_readdata, m_rsp.data);
          mon_pend--;
        end
      end else begin
        chk("no_strobe", cli_readdatavalid, '0);
      end
      prev_busy = (mem_read || mem_write) && mem_waitrequest;
      prev_op   = {mem_read, mem_write};
      prev_a    = mem_address;
      prev_d    = mem_writedata;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, grants;
    drive_idle();
    for (int k = 0; k < C; k++) req_v[k] = 1'b0;
    ptr = 0; outst = 0; stage_cnt = 0; exp_err = 1'b0; mon_pend = 0; prev_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_writedata", mem_writedata, 0);
    chk("rst_rdvalid", cli_readdatavalid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_err", err, 0);
    chk("rst_wait", cli_waitrequest, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    repeat (500) cycle_step(1'b1);
    n = 0;
    while (n < 400 && (cmd_q.size() > 0 || mem_q.size() > 0 || exp_rsp_q.size() > 0 ||
                       req_v[0] || req_v[1] || req_v[2] || req_v[3])) begin
      cycle_step(1'b0);
      n++;
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("drain_done", n < 400, 1);
    chk("sticky_err", err, exp_err);
    mon_en = 1'b0;

    // Credit limit: client 0 reads with no responses; writes still pass.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    cli_read = 4'b0001;
    cli_address[0 +: AW] = AW'(25'h100);
    grants = 0;
    repeat (8) begin
      @(negedge clk);
      if (!cli_waitrequest[0]) grants++;
    end
    chk("credit_grants", grants, MP);
    chk("credit_pending", pending, MP);
    @(posedge clk); #1;
    cli_write = 4'b0010;
    cli_address[AW +: AW] = AW'(25'h80);
    cli_writedata[DW +: DW] = 16'hBEEF;
    @(negedge clk);
    chk("write_no_credit", cli_waitrequest, 4'b1101);
    @(posedge clk); #1;
    cli_write = '0;
    mem_readdatavalid = 1'b1;
    mem_readdata = 16'h1234;
    @(negedge clk);
    chk("credit_rsp_strobe", cli_readdatavalid, 4'b0001);
    chk("credit_rsp_data", cli_readdata, 16'h1234);
    chk("credit_return", cli_waitrequest, 4'b1110);
    @(posedge clk); #1;
    mem_readdatavalid = 1'b0;
    cli_read = '0;
    @(negedge clk);
    chk("reissue_op", {mem_read, mem_write}, 2'b10);
    chk("reissue_addr", mem_address, 25'h100);
    chk("reissue_pending", pending, MP - 1);
    chk("no_err_yet", err, 0);

    // Reset with reads in flight, then a late response.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_pending", pending, 0);
    chk("midrst_err", err, 0);
    chk("midrst_mem_read", mem_read, 0);
    @(posedge clk); #1 mem_readdatavalid = 1'b1;
    @(negedge clk);
    chk("late_rsp_strobe", cli_readdatavalid, 0);
    @(posedge clk); #1 mem_readdatavalid = 1'b0;
    @(negedge clk);
    chk("late_rsp_err", err, 1);
    chk("late_rsp_pending", pending, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
